if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 The block SHALL have parameter PC_STEP, default 4, meaning the byte increment between sequential fetches.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1: synchronous active-low reset.
REQ-006 Port freeze, input, 1: hazard stall; hold the PC and the IF/ID register.
REQ-007 Port branch_taken, input, 1: redirect fetch and flush the IF/ID register.
REQ-008 Port branch_addr, input, 32: redirect target byte address.
REQ-009 Port imem_addr, output, 32: current fetch address to instruction memory; equals PC register.
REQ-010 Port imem_data, input, 32: instruction word returned combinationally for imem_addr.
REQ-011 Port pc, output, 32: registered fetch address + PC_STEP, consumed by ID stage pc.
REQ-012 Port instruction, output, 32: registered instruction, consumed by ID stage instruction_memory.
REQ-013 Port valid, output, 1: registered flag; 1 means pc/instruction hold a real fetched instruction.

Function
REQ-014 PC register SHALL update every rising edge per priority: reset > branch_taken > freeze > sequential.
REQ-015 On branch_taken=1 the PC SHALL load {branch_addr[31:2],2'b00}, regardless of freeze.
REQ-016 On freeze=1 and branch_taken=0 the PC SHALL hold its value.
REQ-017 Otherwise the PC SHALL load PC + PC_STEP, modulo 2^32 (0xFFFF_FFFC + 4 -> 0x0000_0000, no flag).
REQ-018 imem_addr SHALL equal the PC register combinationally, with zero-cycle latency to imem_data.
REQ-019 On branch_taken=1 the IF/ID register SHALL load instruction=32'h0, pc=32'h0, valid=0 (flush beats freeze).
REQ-020 On freeze=1 and branch_taken=0 the IF/ID register SHALL hold pc, instruction and valid unchanged.
REQ-021 Otherwise the IF/ID register SHALL load pc=PC+PC_STEP, instruction=imem_data, valid=1.
REQ-022 Fetch-to-ID latency SHALL be exactly one cycle: a word fetched at edge N appears on outputs after edge N+1.
REQ-023 A branch SHALL cost exactly one bubble: the first instruction at the target appears with valid=1 one cycle after the flushed slot.
REQ-024 Consecutive branch_taken cycles SHALL each redirect the PC and keep valid=0.
REQ-025 freeze held for K cycles SHALL stall exactly K cycles, with no fetch lost or duplicated.
REQ-026 imem_data SHALL be sampled only when the IF/ID register loads; its value during freeze or flush SHALL be ignored.

Reset
REQ-027 With rst_n=0 at a rising edge, PC SHALL become RESET_PC and pc, instruction and valid SHALL become 32'h0, 32'h0 and 0.
REQ-028 Reset SHALL override freeze and branch_taken in the same cycle.
REQ-029 Reset asserted mid-stall or mid-branch SHALL discard all pending state.
REQ-030 In the first cycle after rst_n rises, imem_addr SHALL equal RESET_PC and valid SHALL remain 0 until the first load edge.
REQ-031 No output SHALL be X after the first reset edge.

Verification
REQ-032 Sequential fetch: reset, release, imem returns addr-tagged words -> after edges 1..3, (pc,instruction,valid) = (4,word@0,1), (8,word@4,1), (12,word@8,1).
REQ-033 Stall: freeze=1 for 3 cycles starting when PC=8 -> imem_addr stays 8, outputs hold (8,word@4,1) for 3 cycles, then resume with (12,word@8,1).
REQ-034 Branch: branch_taken=1 with branch_addr=0x0000_0103 while PC=0x10 -> next PC=0x100, outputs (0,0,0) for one cycle, then (0x104,word@0x100,1).
REQ-035 Branch during freeze: freeze=1 and branch_taken=1 with branch_addr=0x40 -> PC=0x40 and valid=0; with freeze still 1 next cycle, PC holds 0x40 and valid stays 0.
REQ-036 Wrap: RESET_PC=0xFFFF_FFF8 -> imem_addr sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4, and the pc output after the 0xFFFF_FFFC fetch reads 0x0.
REQ-037 Reset mid-operation: rst_n=0 for one edge during freeze with PC=0x20 -> PC=RESET_PC and outputs (0,0,0); sequential fetch from RESET_PC follows after release.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, imem address drive and IF/ID register.
// Branch redirect flushes the IF/ID slot; freeze holds both PC and IF/ID.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        valid
);

    logic [31:0] pc_q;
    logic [31:0] pc_seq;
    logic [31:0] target;

    assign pc_seq    = pc_q + 32'(PC_STEP);
    assign target    = {branch_addr[31:2], 2'b00};
    assign imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (branch_taken) begin
            pc_q <= target;
        end else if (!freeze) begin
            pc_q <= pc_seq;
        end
    end

    // A taken branch kills the word fetched this cycle, even under freeze.
    always_ff @(posedge clk) begin
        if (!rst_n || branch_taken) begin
            pc          <= 32'h0;
            instruction <= 32'h0;
            valid       <= 1'b0;
        end else if (!freeze) begin
            pc          <= pc_seq;
            instruction <= imem_data;
            valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, branch, wrap and reset cases.
// Instruction memory returns an address-tagged word combinationally.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;

    logic        rst_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_data_w;
    logic [31:0] pc_w;
    logic [31:0] instruction_w;
    logic        valid_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_data   = word(imem_addr);
    assign imem_data_w = word(imem_addr_w);

    if_stage dut (
        .clk(clk),
        .rst_n(rst_n),
        .freeze(freeze),
        .branch_taken(branch_taken),
        .branch_addr(branch_addr),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .pc(pc),
        .instruction(instruction),
        .valid(valid)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_w (
        .clk(clk),
        .rst_n(rst_w),
        .freeze(1'b0),
        .branch_taken(1'b0),
        .branch_addr(32'h0),
        .imem_addr(imem_addr_w),
        .imem_data(imem_data_w),
        .pc(pc_w),
        .instruction(instruction_w),
        .valid(valid_w)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic out(input string tag, input logic [31:0] a,
                       input logic [31:0] p, input logic [31:0] i,
                       input logic v);
        chk({tag, ".addr"}, imem_addr, a);
        chk({tag, ".pc"}, pc, p);
        chk({tag, ".instr"}, instruction, i);
        chk({tag, ".valid"}, {31'h0, valid}, {31'h0, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        rst_w        = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;

        step();
        out("reset", 32'h0, 32'h0, 32'h0, 1'b0);

        rst_n = 1'b1;
        #1;
        out("post_rst", 32'h0, 32'h0, 32'h0, 1'b0);

        step();
        out("seq1", 32'h4, 32'h4, word(32'h0), 1'b1);
        step();
        out("seq2", 32'h8, 32'h8, word(32'h4), 1'b1);

        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            out("stall", 32'h8, 32'h8, word(32'h4), 1'b1);
        end
        freeze = 1'b0;
        step();
        out("resume", 32'hC, 32'hC, word(32'h8), 1'b1);
        step();
        out("seq4", 32'h10, 32'h10, word(32'hC), 1'b1);

        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0103;
        step();
        out("br_flush", 32'h100, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        step();
        out("br_target", 32'h104, 32'h104, word(32'h100), 1'b1);

        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h40;
        step();
        out("br_frz", 32'h40, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        step();
        out("br_frz_hold", 32'h40, 32'h0, 32'h0, 1'b0);

        freeze       = 1'b0;
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        step();
        out("br2a", 32'h200, 32'h0, 32'h0, 1'b0);
        branch_addr = 32'h302;
        step();
        out("br2b", 32'h300, 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        step();
        out("br2_tgt", 32'h304, 32'h304, word(32'h300), 1'b1);

        branch_taken = 1'b1;
        branch_addr  = 32'h20;
        step();
        branch_taken = 1'b0;
        freeze       = 1'b1;
        step();
        out("pre_rst", 32'h20, 32'h0, 32'h0, 1'b0);
        rst_n        = 1'b0;
        branch_taken = 1'b1;
        branch_addr  = 32'h80;
        step();
        out("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        rst_n        = 1'b1;
        branch_taken = 1'b0;
        freeze       = 1'b0;
        step();
        out("rst_seq1", 32'h4, 32'h4, word(32'h0), 1'b1);
        step();
        out("rst_seq2", 32'h8, 32'h8, word(32'h4), 1'b1);

        chk("wrap.addr0", imem_addr_w, 32'hFFFF_FFF8);
        chk("wrap.valid0", {31'h0, valid_w}, 32'h0);
        rst_w = 1'b1;
        step();
        chk("wrap.addr1", imem_addr_w, 32'hFFFF_FFFC);
        chk("wrap.pc1", pc_w, 32'hFFFF_FFFC);
        step();
        chk("wrap.addr2", imem_addr_w, 32'h0);
        chk("wrap.pc2", pc_w, 32'h0);
        chk("wrap.instr2", instruction_w, word(32'hFFFF_FFFC));
        step();
        chk("wrap.addr3", imem_addr_w, 32'h4);
        chk("wrap.pc3", pc_w, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
